// File: rtl/or1200_pkg.sv
// Shared definitions for the OR1K-subset single-cycle core: opcodes, ALU
// operation codes, instruction field positions and the default ROM image.
package or1200_pkg;

    // Primary opcodes, insn[31:26]
    localparam logic [5:0] OP_J     = 6'h00;
    localparam logic [5:0] OP_BF    = 6'h04;
    localparam logic [5:0] OP_NOP   = 6'h05;
    localparam logic [5:0] OP_MOVHI = 6'h06;
    localparam logic [5:0] OP_ADDI  = 6'h27;
    localparam logic [5:0] OP_ANDI  = 6'h29;
    localparam logic [5:0] OP_ORI   = 6'h2A;
    localparam logic [5:0] OP_XORI  = 6'h2B;
    localparam logic [5:0] OP_ALU   = 6'h38;
    localparam logic [5:0] OP_SF    = 6'h39;

    // Register-register sub-ops in insn[3:0] of OP_ALU
    localparam logic [3:0] SUB_ADD = 4'd0;
    localparam logic [3:0] SUB_SUB = 4'd2;
    localparam logic [3:0] SUB_AND = 4'd3;
    localparam logic [3:0] SUB_OR  = 4'd4;
    localparam logic [3:0] SUB_XOR = 4'd5;

    // Set-flag condition selected by the rD field of OP_SF
    localparam logic [4:0] SF_EQ = 5'd0;
    localparam logic [4:0] SF_NE = 5'd1;

    // Instruction field positions
    localparam int FLD_OP_HI   = 31;
    localparam int FLD_OP_LO   = 26;
    localparam int FLD_RD_HI   = 25;
    localparam int FLD_RD_LO   = 21;
    localparam int FLD_RA_HI   = 20;
    localparam int FLD_RA_LO   = 16;
    localparam int FLD_RB_HI   = 15;
    localparam int FLD_RB_LO   = 11;
    localparam int FLD_I16_HI  = 15;
    localparam int FLD_I16_LO  = 0;
    localparam int FLD_I26_HI  = 25;
    localparam int FLD_I26_LO  = 0;
    localparam int FLD_SUB_HI  = 3;
    localparam int FLD_SUB_LO  = 0;

    // Default ROM image
    localparam logic [31:0] ROM_WORD0 = 32'h9C600005;
    localparam logic [31:0] ROM_WORD1 = 32'h00000000;
    localparam logic [31:0] ROM_NOP   = 32'h15000000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_PASSB,
        ALU_SFEQ,
        ALU_SFNE
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] v);
        return {16'h0000, v};
    endfunction

endpackage

// File: rtl/or1200_alu.sv
// Combinational ALU: arithmetic/logic result plus the set-flag compare.
module or1200_alu
    import or1200_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        flag
);

    always_comb begin
        result = 32'h0;
        flag   = 1'b0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_PASSB: result = b;
            ALU_SFEQ:  flag   = (a == b);
            ALU_SFNE:  flag   = (a != b);
            default:   result = 32'h0;
        endcase
    end

endmodule

// File: rtl/or1200_cpu.sv
// Single-cycle, non-pipelined OR1K-subset core with an internal instruction
// ROM; one instruction is fetched, executed and retired per clock.
module or1200_cpu
    import or1200_pkg::*;
#(
    parameter int          IMEM_WORDS = 64,
    parameter logic [31:0] RESET_PC   = 32'h0
)
(
    input  logic clk,
    input  logic rst
);

    localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;

    logic [31:0] pc;
    logic [31:0] insn;
    logic        flag;
    logic [31:0] eax;

    logic [31:0] r_imem [IMEM_WORDS] = '{0: ROM_WORD0, 1: ROM_WORD1, default: ROM_NOP};
    logic [31:0] r_gpr  [32];

    logic [IDX_W-1:0] w_idx;
    logic [5:0]       w_opcode;
    logic [4:0]       w_rd;
    logic [4:0]       w_ra;
    logic [4:0]       w_rb;
    logic [15:0]      w_imm16;
    logic [25:0]      w_imm26;
    logic [3:0]       w_subop;
    logic [31:0]      w_ra_val;
    logic [31:0]      w_rb_val;
    logic [31:0]      w_alu_b;
    alu_op_e          w_alu_op;
    logic [31:0]      w_alu_result;
    logic             w_alu_flag;
    logic             w_gpr_we;
    logic             w_flag_we;
    logic [31:0]      w_pc_seq;
    logic [31:0]      w_pc_jump;
    logic [31:0]      w_next_pc;

    // Fetch wraps at the end of the ROM regardless of the pc upper bits
    assign w_idx = IDX_W'(pc[31:2] % 30'(IMEM_WORDS));
    assign insn  = r_imem[w_idx];

    assign w_opcode = insn[FLD_OP_HI:FLD_OP_LO];
    assign w_rd     = insn[FLD_RD_HI:FLD_RD_LO];
    assign w_ra     = insn[FLD_RA_HI:FLD_RA_LO];
    assign w_rb     = insn[FLD_RB_HI:FLD_RB_LO];
    assign w_imm16  = insn[FLD_I16_HI:FLD_I16_LO];
    assign w_imm26  = insn[FLD_I26_HI:FLD_I26_LO];
    assign w_subop  = insn[FLD_SUB_HI:FLD_SUB_LO];

    // r0 is hardwired to zero on the read side; writes to it are dropped
    assign w_ra_val = (w_ra == 5'd0) ? 32'h0 : r_gpr[w_ra];
    assign w_rb_val = (w_rb == 5'd0) ? 32'h0 : r_gpr[w_rb];

    assign w_pc_seq  = pc + 32'd4;
    assign w_pc_jump = pc + {{4{w_imm26[25]}}, w_imm26, 2'b00};

    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_b   = w_rb_val;
        w_gpr_we  = 1'b0;
        w_flag_we = 1'b0;
        w_next_pc = w_pc_seq;
        case (w_opcode)
            OP_ADDI: begin
                w_alu_op = ALU_ADD;
                w_alu_b  = sext16(w_imm16);
                w_gpr_we = 1'b1;
            end
            OP_ANDI: begin
                w_alu_op = ALU_AND;
                w_alu_b  = zext16(w_imm16);
                w_gpr_we = 1'b1;
            end
            OP_ORI: begin
                w_alu_op = ALU_OR;
                w_alu_b  = zext16(w_imm16);
                w_gpr_we = 1'b1;
            end
            OP_XORI: begin
                w_alu_op = ALU_XOR;
                w_alu_b  = sext16(w_imm16);
                w_gpr_we = 1'b1;
            end
            OP_MOVHI: begin
                w_alu_op = ALU_PASSB;
                w_alu_b  = {w_imm16, 16'h0000};
                w_gpr_we = 1'b1;
            end
            OP_ALU: begin
                case (w_subop)
                    SUB_ADD: begin w_alu_op = ALU_ADD; w_gpr_we = 1'b1; end
                    SUB_SUB: begin w_alu_op = ALU_SUB; w_gpr_we = 1'b1; end
                    SUB_AND: begin w_alu_op = ALU_AND; w_gpr_we = 1'b1; end
                    SUB_OR:  begin w_alu_op = ALU_OR;  w_gpr_we = 1'b1; end
                    SUB_XOR: begin w_alu_op = ALU_XOR; w_gpr_we = 1'b1; end
                    default: w_gpr_we = 1'b0;
                endcase
            end
            OP_SF: begin
                case (w_rd)
                    SF_EQ:   begin w_alu_op = ALU_SFEQ; w_flag_we = 1'b1; end
                    SF_NE:   begin w_alu_op = ALU_SFNE; w_flag_we = 1'b1; end
                    default: w_flag_we = 1'b0;
                endcase
            end
            OP_J:    w_next_pc = w_pc_jump;
            OP_BF:   w_next_pc = flag ? w_pc_jump : w_pc_seq;
            default: w_next_pc = w_pc_seq;
        endcase
    end

    or1200_alu u_alu (
        .a      (w_ra_val),
        .b      (w_alu_b),
        .op     (w_alu_op),
        .result (w_alu_result),
        .flag   (w_alu_flag)
    );

    // Architectural state update; operands were read before this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_PC;
            flag <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_gpr[i] <= 32'h0;
            end
        end else begin
            pc <= w_next_pc;
            if (w_flag_we) begin
                flag <= w_alu_flag;
            end
            if (w_gpr_we && (w_rd != 5'd0)) begin
                r_gpr[w_rd] <= w_alu_result;
            end
        end
    end

    assign eax = r_gpr[3];

endmodule

// File: tb/tb_or1200_cpu.sv
// Self-checking bench for or1200_cpu: directed ROM programs plus random
// programs compared cycle by cycle against an instruction-level model.
module tb_or1200_cpu;

    localparam int NW = 64;

    logic clk;
    logic rst;

    int chk_cnt;
    int pass_cnt;

    // Instruction-level reference state
    logic [31:0] m_rom [NW];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;
    logic        m_flag;

    or1200_cpu #(.IMEM_WORDS(NW), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_rom(input logic [31:0] prog [$]);
        for (int i = 0; i < NW; i++) begin
            m_rom[i] = (i < prog.size()) ? prog[i] : 32'h15000000;
            dut.r_imem[i] = m_rom[i];
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_flag = 1'b0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] ins, a, b, res;
        int op, rd, ra, rb, imm, simm, off;
        bit wr;
        ins  = m_rom[(m_pc / 4) % NW];
        op   = int'(ins >> 26);
        rd   = int'((ins >> 21) & 32'h1F);
        ra   = int'((ins >> 16) & 32'h1F);
        rb   = int'((ins >> 11) & 32'h1F);
        imm  = int'(ins & 32'hFFFF);
        simm = (imm >= 32768) ? imm - 65536 : imm;
        off  = int'(ins & 32'h03FF_FFFF);
        if (off >= 33554432) off = off - 67108864;
        a = (ra == 0) ? 32'h0 : m_reg[ra];
        b = (rb == 0) ? 32'h0 : m_reg[rb];
        res = 32'h0;
        wr = 1'b0;
        m_pc = m_pc + 32'd4;
        case (op)
            'h27: begin res = a + 32'(simm); wr = 1; end
            'h29: begin res = a & 32'(imm);  wr = 1; end
            'h2A: begin res = a | 32'(imm);  wr = 1; end
            'h2B: begin res = a ^ 32'(simm); wr = 1; end
            'h06: begin res = 32'(imm) * 32'd65536; wr = 1; end
            'h38: begin
                wr = 1;
                case (ins & 32'hF)
                    0: res = a + b;
                    2: res = a - b;
                    3: res = a & b;
                    4: res = a | b;
                    5: res = a ^ b;
                    default: wr = 0;
                endcase
            end
            'h39: begin
                if (rd == 0) m_flag = (a == b);
                else if (rd == 1) m_flag = (a != b);
            end
            'h00: m_pc = m_pc - 32'd4 + 32'(off * 4);
            'h04: if (m_flag) m_pc = m_pc - 32'd4 + 32'(off * 4);
            default: ;
        endcase
        if (wr && rd != 0) m_reg[rd] = res;
    endtask

    function automatic logic [31:0] gen_insn();
        int k, rd, ra, rb, off;
        logic [15:0] imm;
        int subs [5] = '{0, 2, 3, 4, 5};
        int unk  [4] = '{'h01, 'h11, 'h3F, 'h2C};
        k   = $urandom_range(0, 11);
        rd  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 3;
        ra  = $urandom_range(0, 3);
        rb  = $urandom_range(0, 3);
        imm = 16'($urandom);
        off = $urandom_range(0, 8) - 3;
        case (k)
            0:  return {6'h27, 5'(rd), 5'(ra), imm};
            1:  return {6'h29, 5'(rd), 5'(ra), imm};
            2:  return {6'h2A, 5'(rd), 5'(ra), imm};
            3:  return {6'h2B, 5'(rd), 5'(ra), imm};
            4:  return {6'h06, 5'(rd), 5'(ra), imm};
            5, 11: return {6'h38, 5'(rd), 5'(ra), 5'(rb), 7'h0, 4'(subs[$urandom_range(0, 4)])};
            6:  return {6'h39, 5'($urandom_range(0, 1)), 5'(ra), 5'(rb), 11'h0};
            7:  return {6'h00, 26'(off)};
            8:  return {6'h04, 26'(off)};
            9:  return 32'h15000000;
            default: return {6'(unk[$urandom_range(0, 3)]), 26'($urandom)};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick();
        chk_cnt++;
        if (dut.pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", dut.pc, 32'h0);
        else pass_cnt++;
        chk_cnt++;
        if (dut.eax !== 32'h0) $display("FAIL reset_eax: got %h want %h", dut.eax, 32'h0);
        else pass_cnt++;
        chk_cnt++;
        if (dut.flag !== 1'b0) $display("FAIL reset_flag: got %b want 0", dut.flag);
        else pass_cnt++;
    endtask

    task automatic test_default_rom();
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (dut.eax !== 32'd5) $display("FAIL default_eax: got %h want %h", dut.eax, 32'd5);
        else pass_cnt++;
        chk_cnt++;
        if (dut.pc !== 32'd4) $display("FAIL default_pc: got %h want %h", dut.pc, 32'd4);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (dut.eax !== 32'd5 || dut.pc !== 32'd4)
                $display("FAIL selfloop_%0d: got eax=%h pc=%h want eax=5 pc=4", i, dut.eax, dut.pc);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        chk_cnt++;
        if (dut.pc !== 32'h0 || dut.eax !== 32'h0)
            $display("FAIL midreset: got pc=%h eax=%h want 0 0", dut.pc, dut.eax);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (dut.eax !== 32'd5 || dut.pc !== 32'd4)
            $display("FAIL midreset_rerun: got eax=%h pc=%h want 5 4", dut.eax, dut.pc);
        else pass_cnt++;
    endtask

    task automatic test_movhi_ori();
        logic [31:0] p [$] = '{32'h18601234, 32'hA8635678};
        rst = 1'b1;
        load_rom(p);
        tick();
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (dut.eax !== 32'h12340000) $display("FAIL movhi: got %h want %h", dut.eax, 32'h12340000);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (dut.eax !== 32'h12345678) $display("FAIL ori: got %h want %h", dut.eax, 32'h12345678);
        else pass_cnt++;
    endtask

    task automatic test_addi_wrap();
        logic [31:0] p [$] = '{32'h9C60FFFF, 32'h9C630001};
        rst = 1'b1;
        load_rom(p);
        tick();
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (dut.eax !== 32'hFFFFFFFF) $display("FAIL addi_neg: got %h want %h", dut.eax, 32'hFFFFFFFF);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (dut.eax !== 32'h0) $display("FAIL addi_wrap: got %h want %h", dut.eax, 32'h0);
        else pass_cnt++;
    endtask

    task automatic test_sfeq_bf();
        logic [31:0] p [$] = '{32'hE4000000, 32'h10000003, 32'h15000000, 32'h15000000,
                               32'h9C600009, 32'h9C000007, 32'hE0600000};
        rst = 1'b1;
        load_rom(p);
        tick();
        rst = 1'b0;
        tick();
        chk_cnt++;
        if (dut.flag !== 1'b1 || dut.pc !== 32'd4)
            $display("FAIL sfeq: got flag=%b pc=%h want 1 4", dut.flag, dut.pc);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if (dut.pc !== 32'd16) $display("FAIL bf_taken: got %h want %h", dut.pc, 32'd16);
        else pass_cnt++;
        tick();
        tick();
        tick();
        chk_cnt++;
        if (dut.eax !== 32'h0 || dut.pc !== 32'd28)
            $display("FAIL r0_write: got eax=%h pc=%h want 0 1c", dut.eax, dut.pc);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] p [$];
        for (int prog = 0; prog < 12; prog++) begin
            p.delete();
            for (int i = 0; i < NW; i++) p.push_back(gen_insn());
            rst = 1'b1;
            load_rom(p);
            tick();
            model_reset();
            for (int c = 0; c < 120; c++) begin
                rst = ($urandom_range(0, 31) == 0);
                tick();
                if (rst) model_reset();
                else model_step();
                chk_cnt++;
                if (dut.pc !== m_pc || dut.eax !== m_reg[3] || dut.flag !== m_flag)
                    $display("FAIL rand_p%0d_c%0d: got pc=%h eax=%h flag=%b want pc=%h eax=%h flag=%b",
                             prog, c, dut.pc, dut.eax, dut.flag, m_pc, m_reg[3], m_flag);
                else pass_cnt++;
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] p [$];
        // Dense register-to-register chains on r3 exercising read-before-write
        p.delete();
        for (int i = 0; i < NW; i++) begin
            if ($urandom_range(0, 1) == 0)
                p.push_back({6'h38, 5'd3, 5'd3, 5'd3, 7'h0, 4'(($urandom_range(0, 1) == 0) ? 0 : 2)});
            else
                p.push_back({6'h27, 5'd3, 5'd3, 16'($urandom)});
        end
        rst = 1'b1;
        load_rom(p);
        tick();
        model_reset();
        rst = 1'b0;
        for (int c = 0; c < 150; c++) begin
            tick();
            model_step();
            chk_cnt++;
            if (dut.pc !== m_pc || dut.eax !== m_reg[3])
                $display("FAIL b2b_c%0d: got pc=%h eax=%h want pc=%h eax=%h",
                         c, dut.pc, dut.eax, m_pc, m_reg[3]);
            else pass_cnt++;
        end
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        rst = 1'b1;
        test_reset();
        test_default_rom();
        test_mid_reset();
        test_movhi_ori();
        test_addi_wrap();
        test_sfeq_bf();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
